// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: FSM state encodings, error-flag
// bit positions and the serial line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int ERR_FRAME    = 0;
  localparam int ERR_PARITY   = 1;
  localparam int ERR_OVERFLOW = 2;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Circular receive buffer. Pointers wrap naturally because DEPTH is a power
// of two; a push is accepted while full only if a pop frees a slot the same cycle.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_io.sv
// UART receiver feeding a FIFO, plus a transmitter that drains the whole FIFO
// back out on a tx_start rising edge. Sticky error flags cover overflow/parity/frame.
module uart_buffered_io
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic                   tx,
  input  logic                   tx_start,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      led,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   tx_busy,
  output logic [2:0]             err,
  output logic [2:0]             rx_state_o,
  output logic [2:0]             tx_state_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_state_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [BW-1:0]     rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_par_bad_q, rx_frame_wait_q;
  logic [DATA_W-1:0] led_q;

  tx_state_e         tx_state_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [BW-1:0]     tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_par_q, tx_q, tx_start_q;

  logic [2:0]        err_q, err_d;
  logic              rx_tick, tx_tick, rx_push, tx_pop, tx_start_edge;
  logic              ev_frame, ev_parity, ev_overflow;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign rx_tick       = (rx_cnt_q == BIT_LAST);
  assign tx_tick       = (tx_cnt_q == BIT_LAST);
  assign tx_start_edge = tx_start && !tx_start_q;
  assign rx_push   = (rx_state_q == RX_STOP) && !rx_frame_wait_q && rx_tick
                   && rx_sync_q && !rx_par_bad_q;
  assign ev_frame  = (rx_state_q == RX_STOP) && !rx_frame_wait_q && rx_tick && !rx_sync_q;
  assign ev_parity = (rx_state_q == RX_PARITY) && rx_tick && (rx_sync_q != ^rx_shift_q);
  assign ev_overflow = rx_push && fifo_full && !tx_pop;
  assign tx_pop = !fifo_empty && (((tx_state_q == TX_IDLE) && tx_start_edge)
                                || ((tx_state_q == TX_STOP) && tx_tick));

  uart_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (tx_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

  // Receiver: samples mid-bit, counting from the middle of the start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q       <= IDLE_LEVEL;
      rx_sync_q       <= IDLE_LEVEL;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_bad_q    <= 1'b0;
      rx_frame_wait_q <= 1'b0;
      led_q           <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_par_bad_q <= 1'b0;
            rx_state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
            if (rx_bit_q == DATA_LAST) rx_state_q <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            else rx_bit_q <= rx_bit_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_cnt_q     <= '0;
            rx_par_bad_q <= ev_parity;
            rx_state_q   <= RX_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_STOP: begin
          if (rx_frame_wait_q) begin
            if (rx_sync_q) begin
              rx_frame_wait_q <= 1'b0;
              rx_state_q      <= RX_IDLE;
            end
          end else if (rx_tick) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
              if (!rx_par_bad_q) led_q <= rx_shift_q;
            end else rx_frame_wait_q <= 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: loads a new word straight out of STOP while the FIFO has data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= IDLE_LEVEL;
    end else begin
      tx_start_q <= tx_start;
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          tx_q     <= IDLE_LEVEL;
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_shift_q <= fifo_rdata;
            tx_par_q   <= ^fifo_rdata;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == DATA_LAST) begin
              tx_state_q <= (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
              tx_q       <= (PARITY_EN != 0) ? tx_par_q : IDLE_LEVEL;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_q       <= IDLE_LEVEL;
            tx_state_q <= TX_STOP;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_state_q <= TX_START;
              tx_q       <= 1'b0;
              tx_shift_q <= fifo_rdata;
              tx_par_q   <= ^fifo_rdata;
            end else begin
              tx_state_q <= TX_IDLE;
              tx_q       <= IDLE_LEVEL;
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Set events win over a same-cycle clear.
  always_comb begin
    err_d = err_clr ? 3'b000 : err_q;
    if (ev_overflow) err_d[ERR_OVERFLOW] = 1'b1;
    if (ev_parity)   err_d[ERR_PARITY]   = 1'b1;
    if (ev_frame)    err_d[ERR_FRAME]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign tx         = tx_q;
  assign led        = led_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign err        = err_q;
  assign rx_state_o = rx_state_q;
  assign tx_state_o = tx_state_q;

endmodule
